// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: ALU ops, next-PC kinds, forwarding selects and M-extension funct3.
package riscv_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSll   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluSlt   = 4'd8,
        AluSltu  = 4'd9,
        AluPassB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        PcNext    = 3'd0,
        PcJal     = 3'd1,
        PcJalr    = 3'd2,
        PcBrZero  = 3'd3,
        PcBrNzero = 3'd4
    } pcsrc_t;

    localparam logic [1:0] FwdRf = 2'b00;
    localparam logic [1:0] FwdW  = 2'b01;
    localparam logic [1:0] FwdM  = 2'b10;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, one step per cycle.
// Only instantiated when MULDIV_EN is defined.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  muldiv_op_t       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] result
);
    localparam int unsigned CntW = $clog2(Width);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [Width-1:0]   ma_q, ma_d, mb_q, mb_d, result_q, result_d;
    muldiv_op_t         op_q, op_d;
    logic               neg_q, neg_d;

    logic               a_neg, b_neg;
    logic [Width-1:0]   mag_a, mag_b;
    logic [Width:0]     mul_sum, div_diff;
    logic [2*Width-1:0] step, prod_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            op_q     <= MdMul;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        a_neg = (op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem}) && a[Width-1];
        b_neg = (op inside {MdMul, MdMulh, MdDiv, MdRem}) && b[Width-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;

        // Multiply: add multiplicand into the high half on LSB, shift right with carry.
        mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + {1'b0, ma_q};
        // Divide: {rem,quo} shifts left; the top bit of acc is the overflow bit of the trial.
        div_diff = acc_q[2*Width-1:Width-1] - {1'b0, mb_q};
        if (op_q[2]) begin
            step = div_diff[Width] ? {acc_q[2*Width-2:0], 1'b0}
                                   : {div_diff[Width-1:0], acc_q[Width-2:0], 1'b1};
        end else begin
            step = acc_q[0] ? {mul_sum, acc_q[Width-1:1]} : {1'b0, acc_q[2*Width-1:1]};
        end
        prod_fix = neg_q ? -step : step;

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    op_d    = op;
                    ma_d    = mag_a;
                    mb_d    = mag_b;
                    acc_d   = op[2] ? {{Width{1'b0}}, mag_a} : {{Width{1'b0}}, mag_b};
                    // Divide-by-zero quotient stays all ones; remainder sign follows dividend.
                    unique case (op)
                        MdDiv, MdDivu: neg_d = (a_neg ^ b_neg) && (b != '0);
                        MdRem, MdRemu: neg_d = a_neg;
                        default:       neg_d = a_neg ^ b_neg;
                    endcase
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(Width - 1)) begin
                        state_d = StDone;
                        unique case (op_q)
                            MdMul:                   result_d = prod_fix[Width-1:0];
                            MdMulh, MdMulhsu, MdMulhu: result_d = prod_fix[2*Width-1:Width];
                            MdDiv, MdDivu:
                                result_d = neg_q ? -step[Width-1:0] : step[Width-1:0];
                            default:
                                result_d = neg_q ? -step[2*Width-1:Width] : step[2*Width-1:Width];
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign done   = (state_q == StDone);
    assign busy   = start && !done;
    assign result = result_q;

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution, optional mul/div.
// Define MULDIV_EN to build the iterative mul/div unit; otherwise the stage is combinational.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  FlushE,
    input  logic [3:0]            ALUControlE,
    input  logic                  ALUsrcE,
    input  logic [2:0]            PCsrcE,
    input  logic                  MulDivE,
    input  logic [2:0]            MulDivOpE,
    input  logic [DATA_WIDTH-1:0] rd1E,
    input  logic [DATA_WIDTH-1:0] rd2E,
    input  logic [DATA_WIDTH-1:0] pcE,
    input  logic [DATA_WIDTH-1:0] ImmExtE,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] ALUResultE,
    output logic [DATA_WIDTH-1:0] WriteDataE,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  PCSrcTakenE,
    output logic                  BusyE
);
    logic [DATA_WIDTH-1:0] src_a, fwd_b, src_b, alu_res, jalr_sum, md_result;
    logic [4:0]            shamt;
    logic                  taken, md_busy, md_done;

    always_comb begin
        unique case (ForwardAE)
            FwdW:    src_a = ResultW;
            FwdM:    src_a = ALUResultM;
            default: src_a = rd1E;
        endcase
        unique case (ForwardBE)
            FwdW:    fwd_b = ResultW;
            FwdM:    fwd_b = ALUResultM;
            default: fwd_b = rd2E;
        endcase
        src_b = ALUsrcE ? ImmExtE : fwd_b;
    end

    assign shamt = src_b[4:0];

    always_comb begin
        alu_res = src_a + src_b;
        case (ALUControlE)
            AluSub:   alu_res = src_a - src_b;
            AluAnd:   alu_res = src_a & src_b;
            AluOr:    alu_res = src_a | src_b;
            AluXor:   alu_res = src_a ^ src_b;
            AluSll:   alu_res = src_a << shamt;
            AluSrl:   alu_res = src_a >> shamt;
            AluSra:   alu_res = $signed(src_a) >>> shamt;
            AluSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            AluSltu:  alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
            AluPassB: alu_res = src_b;
            default:  ;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (PCsrcE)
            PcJal, PcJalr: taken = 1'b1;
            PcBrZero:      taken = (alu_res == '0);
            PcBrNzero:     taken = (alu_res != '0);
            default:       ;
        endcase
    end

    assign jalr_sum    = src_a + ImmExtE;
    assign PCTargetE   = (PCsrcE == PcJalr) ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : pcE + ImmExtE;
    assign PCSrcTakenE = taken && !BusyE;
    assign WriteDataE  = fwd_b;

`ifdef MULDIV_EN
    muldiv_unit #(
        .Width(DATA_WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MulDivE),
        .flush (FlushE),
        .op    (muldiv_op_t'(MulDivOpE)),
        .a     (src_a),
        .b     (src_b),
        .busy  (md_busy),
        .done  (md_done),
        .result(md_result)
    );
`else
    logic unused_md;
    assign unused_md = ^{clk, rst_n, FlushE, MulDivE, MulDivOpE};
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    assign BusyE      = md_busy;
    assign ALUResultE = md_done ? md_result : alu_res;

endmodule
